// File: rtl/dsp_equations_engine.sv
// dsp_equations_engine
// Streams samples from the file port and reduces them with one of SUM, MIN,
// MAX or SCALE, selected through the DSP register bank. SCALE results are also
// written back to a destination file. A sequencing FSM handles the
// read/execute/write steps. The engine also provides sample counting,
// saturation, an acknowledge timeout and an abort.
module dsp_equations_engine #(
    parameter int DW    = 32,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16,
    parameter int FRAC  = 16,
    parameter int TMO   = 1024
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [DW-1:0] dsp_input0_reg,
    input  logic [DW-1:0] dsp_input1_reg,
    input  logic [DW-1:0] dsp_input2_reg,
    input  logic [DW-1:0] dsp_input3_reg,
    output logic [DW-1:0] dsp_output0_reg,
    output logic [DW-1:0] dsp_output1_reg,
    output logic [DW-1:0] dsp_output2_reg,
    output logic [DW-1:0] dsp_output3_reg,
    output logic          start,
    output logic          interrupt,
    output logic          error,
    output logic [7:0]    file_num,
    output logic          file_read,
    output logic          file_write,
    output logic [31:0]   file_write_data,
    input  logic [31:0]   file_read_data,
    input  logic          file_active
);

    localparam int PW = 2 * DW;
    localparam int TW = $clog2(TMO + 1);

    localparam logic [2:0] OP_SUM   = 3'd0;
    localparam logic [2:0] OP_MIN   = 3'd1;
    localparam logic [2:0] OP_MAX   = 3'd2;
    localparam logic [2:0] OP_SCALE = 3'd3;

    localparam logic signed [DW-1:0]    DW_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]    DW_MIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EXEC = 3'd2,
        ST_WR   = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    state_t state_r, state_nx_s;

    logic                    ctrl0_r;
    logic [2:0]              op_r;
    logic                    irq_en_r;
    logic [CNT_W-1:0]        n_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [7:0]              src_r;
    logic [7:0]              dst_r;
    logic signed [DW-1:0]    coef_r;
    logic signed [DW-1:0]    data_r;
    logic signed [DW-1:0]    y_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [TW-1:0]           tmo_r;
    logic [DW-1:0]           out0_r;
    logic [DW-1:0]           out1_r;
    logic                    busy_r, done_r, ovf_r, tmo_flag_r, aborted_r;
    logic                    start_r, irq_r, error_r;
    logic                    file_read_r, file_write_r;
    logic [7:0]              file_num_r;
    logic [31:0]             file_write_data_r;

    logic                    idle_like_s, start_acc_s, abort_s, tmo_hit_s;
    logic [CNT_W-1:0]        n_in_s, cnt_inc_s;
    logic [7:0]              src_sel_s;
    logic signed [ACC_W:0]   sum_s;
    logic                    sum_ovf_s;
    logic signed [ACC_W-1:0] sum_sat_s, dext_s, res_s;
    logic signed [PW-1:0]    prod_s, sh_s;
    logic                    scale_ovf_s;
    logic signed [DW-1:0]    y_s;
    logic                    done_ent_s, err_ent_s;
    logic                    unused_s;

    assign unused_s = ^{dsp_input0_reg[DW-1:6], dsp_input1_reg[DW-1:16],
                        dsp_input2_reg[DW-1:CNT_W]};

    // Control decode: start edge, abort qualification and counters.
    assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR);
    assign start_acc_s = dsp_input0_reg[0] & ~ctrl0_r & idle_like_s;
    assign abort_s     = dsp_input0_reg[5] & ~idle_like_s;
    assign n_in_s      = dsp_input2_reg[CNT_W-1:0];
    assign cnt_inc_s   = cnt_r + CNT_W'(1);
    assign tmo_hit_s   = (tmo_r == TW'(TMO - 1));
    assign src_sel_s   = start_acc_s ? dsp_input1_reg[7:0] : src_r;

    // Arithmetic: saturating accumulate, sign-extended sample, scaled product.
    assign sum_s       = (ACC_W+1)'(acc_r) + (ACC_W+1)'(data_r);
    assign sum_ovf_s   = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    assign sum_sat_s   = sum_ovf_s ? (sum_s[ACC_W] ? ACC_MIN : ACC_MAX) : sum_s[ACC_W-1:0];
    assign dext_s      = ACC_W'(data_r);
    assign prod_s      = PW'(data_r) * PW'(coef_r);
    assign sh_s        = prod_s >>> FRAC;
    assign scale_ovf_s = ~(&sh_s[PW-1:DW-1]) & (|sh_s[PW-1:DW-1]);
    assign y_s         = scale_ovf_s ? (sh_s[PW-1] ? DW_MIN : DW_MAX) : sh_s[DW-1:0];
    assign res_s       = (op_r == OP_SCALE) ? ACC_W'(y_r) : acc_r;

    assign done_ent_s  = (state_r == ST_NEXT) && (state_nx_s == ST_DONE);
    assign err_ent_s   = (state_nx_s == ST_ERR) && (state_r != ST_ERR);

    // State register.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort takes priority over any busy-state progress.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_acc_s) begin
                    if (n_in_s == {CNT_W{1'b0}}) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_RD;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_RD: begin
                if (abort_s) begin
                    state_nx_s = ST_IDLE;
                end else if (file_active) begin
                    state_nx_s = ST_EXEC;
                end else if (tmo_hit_s) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_RD;
                end
            end
            ST_EXEC: begin
                if (abort_s) begin
                    state_nx_s = ST_IDLE;
                end else if (op_r == OP_SCALE) begin
                    state_nx_s = ST_WR;
                end else begin
                    state_nx_s = ST_NEXT;
                end
            end
            ST_WR: begin
                if (abort_s) begin
                    state_nx_s = ST_IDLE;
                end else if (file_active) begin
                    state_nx_s = ST_NEXT;
                end else if (tmo_hit_s) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_WR;
                end
            end
            ST_NEXT: begin
                if (abort_s) begin
                    state_nx_s = ST_IDLE;
                end else if (cnt_inc_s == n_r) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Datapath, status and registered file-port/handshake outputs.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ctrl0_r           <= 1'b0;
            op_r              <= 3'd0;
            irq_en_r          <= 1'b0;
            n_r               <= {CNT_W{1'b0}};
            cnt_r             <= {CNT_W{1'b0}};
            src_r             <= 8'd0;
            dst_r             <= 8'd0;
            coef_r            <= {DW{1'b0}};
            data_r            <= {DW{1'b0}};
            y_r               <= {DW{1'b0}};
            acc_r             <= {ACC_W{1'b0}};
            tmo_r             <= {TW{1'b0}};
            out0_r            <= {DW{1'b0}};
            out1_r            <= {DW{1'b0}};
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
            ovf_r             <= 1'b0;
            tmo_flag_r        <= 1'b0;
            aborted_r         <= 1'b0;
            start_r           <= 1'b0;
            irq_r             <= 1'b0;
            error_r           <= 1'b0;
            file_read_r       <= 1'b0;
            file_write_r      <= 1'b0;
            file_num_r        <= 8'd0;
            file_write_data_r <= 32'd0;
        end else begin
            ctrl0_r      <= dsp_input0_reg[0];
            start_r      <= start_acc_s;
            irq_r        <= 1'b0;
            file_read_r  <= (state_nx_s == ST_RD);
            file_write_r <= (state_nx_s == ST_WR);

            if (state_nx_s == ST_RD) begin
                file_num_r <= src_sel_s;
            end else if (state_nx_s == ST_WR) begin
                file_num_r <= dst_r;
            end else begin
                file_num_r <= 8'd0;
            end

            if ((state_r == ST_EXEC) && (state_nx_s == ST_WR)) begin
                file_write_data_r <= y_s[31:0];
            end else if (state_nx_s != ST_WR) begin
                file_write_data_r <= 32'd0;
            end

            // Timeout counter restarts whenever a new request phase begins.
            if (((state_nx_s == ST_RD) || (state_nx_s == ST_WR)) && (state_nx_s != state_r)) begin
                tmo_r <= {TW{1'b0}};
            end else if ((state_r == ST_RD) || (state_r == ST_WR)) begin
                tmo_r <= tmo_r + TW'(1);
            end else begin
                tmo_r <= {TW{1'b0}};
            end

            if (start_acc_s) begin
                op_r       <= dsp_input0_reg[3:1];
                irq_en_r   <= dsp_input0_reg[4];
                n_r        <= n_in_s;
                src_r      <= dsp_input1_reg[7:0];
                dst_r      <= dsp_input1_reg[15:8];
                coef_r     <= dsp_input3_reg;
                cnt_r      <= {CNT_W{1'b0}};
                ovf_r      <= 1'b0;
                tmo_flag_r <= 1'b0;
                aborted_r  <= 1'b0;
                error_r    <= 1'b0;
                case (dsp_input0_reg[3:1])
                    OP_MIN:  acc_r <= ACC_W'(DW_MAX);
                    OP_MAX:  acc_r <= ACC_W'(DW_MIN);
                    default: acc_r <= {ACC_W{1'b0}};
                endcase
                if (n_in_s == {CNT_W{1'b0}}) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    out0_r <= {DW{1'b0}};
                    out1_r <= {DW{1'b0}};
                    irq_r  <= dsp_input0_reg[4];
                end else begin
                    busy_r <= 1'b1;
                    done_r <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_RD: begin
                        if (!abort_s && file_active) begin
                            data_r <= DW'(signed'(file_read_data));
                        end
                    end
                    ST_EXEC: begin
                        if (!abort_s) begin
                            case (op_r)
                                OP_MIN: begin
                                    if (dext_s < acc_r) begin
                                        acc_r <= dext_s;
                                    end
                                end
                                OP_MAX: begin
                                    if (dext_s > acc_r) begin
                                        acc_r <= dext_s;
                                    end
                                end
                                OP_SCALE: begin
                                    y_r <= y_s;
                                    if (scale_ovf_s) begin
                                        ovf_r <= 1'b1;
                                    end
                                end
                                default: begin
                                    acc_r <= sum_sat_s;
                                    if (sum_ovf_s) begin
                                        ovf_r <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_NEXT: begin
                        if (!abort_s) begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    default: begin
                    end
                endcase

                if (abort_s) begin
                    busy_r    <= 1'b0;
                    aborted_r <= 1'b1;
                end else if (done_ent_s) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    out0_r <= res_s[DW-1:0];
                    out1_r <= DW'(signed'(res_s[ACC_W-1:DW]));
                    irq_r  <= irq_en_r;
                end else if (err_ent_s) begin
                    busy_r     <= 1'b0;
                    tmo_flag_r <= 1'b1;
                    error_r    <= 1'b1;
                    irq_r      <= irq_en_r;
                end
            end
        end
    end

    assign dsp_output0_reg = out0_r;
    assign dsp_output1_reg = out1_r;
    assign dsp_output2_reg = {{(DW-5){1'b0}}, aborted_r, tmo_flag_r, ovf_r, done_r, busy_r};
    assign dsp_output3_reg = DW'(cnt_r);
    assign start           = start_r;
    assign interrupt       = irq_r;
    assign error           = error_r;
    assign file_num        = file_num_r;
    assign file_read       = file_read_r;
    assign file_write      = file_write_r;
    assign file_write_data = file_write_data_r;

endmodule

// File: tb/tb_dsp_equations_engine.sv
// Self-checking bench for dsp_equations_engine: a file-port responder feeds
// samples and checks write-backs against an expected queue; per-run results
// are predicted by a reference model and popped when the engine completes.
module tb_dsp_equations_engine;

    localparam int DW    = 32;
    localparam int ACC_W = 34;
    localparam int CNT_W = 16;
    localparam int FRAC  = 16;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in0, in1, in2, in3;
    logic [31:0] out0, out1, out2, out3;
    logic        start, interrupt, error;
    logic [7:0]  file_num;
    logic        file_read, file_write;
    logic [31:0] file_write_data, file_read_data;
    logic        file_active;

    typedef struct packed {
        logic [31:0] o0;
        logic [31:0] o1;
        logic [31:0] st;
        logic [31:0] cnt;
    } exp_t;

    int          rd_q[$];
    logic [31:0] wr_exp_q[$];
    exp_t        res_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        resp_en;
    int          ack_delay;
    int          wait_cnt;
    logic [7:0]  src_cur, dst_cur;

    always #5 clk = ~clk;

    dsp_equations_engine #(
        .DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W), .FRAC(FRAC), .TMO(TMO)
    ) dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .dsp_input0_reg(in0), .dsp_input1_reg(in1),
        .dsp_input2_reg(in2), .dsp_input3_reg(in3),
        .dsp_output0_reg(out0), .dsp_output1_reg(out1),
        .dsp_output2_reg(out2), .dsp_output3_reg(out3),
        .start(start), .interrupt(interrupt), .error(error),
        .file_num(file_num), .file_read(file_read), .file_write(file_write),
        .file_write_data(file_write_data), .file_read_data(file_read_data),
        .file_active(file_active)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: predicts result/status and the SCALE write-back stream.
    task automatic model_push(input logic [2:0] op, input logic [31:0] coef, input int s[$]);
        longint acc, p, y;
        longint amax, amin;
        bit ovf;
        logic [63:0] av;
        exp_t e;
        amax = (longint'(1) <<< (ACC_W - 1)) - 1;
        amin = -amax - 1;
        ovf  = 1'b0;
        case (op)
            3'd1:    acc = 64'sd2147483647;
            3'd2:    acc = -64'sd2147483648;
            default: acc = 64'sd0;
        endcase
        foreach (s[i]) begin
            rd_q.push_back(s[i]);
            case (op)
                3'd1: if (longint'(s[i]) < acc) acc = longint'(s[i]);
                3'd2: if (longint'(s[i]) > acc) acc = longint'(s[i]);
                3'd3: begin
                    p = longint'(s[i]) * longint'(signed'(coef));
                    y = p >>> FRAC;
                    if (y > 64'sd2147483647) begin
                        y = 64'sd2147483647; ovf = 1'b1;
                    end else if (y < -64'sd2147483648) begin
                        y = -64'sd2147483648; ovf = 1'b1;
                    end
                    wr_exp_q.push_back(y[31:0]);
                    acc = y;
                end
                default: begin
                    acc = acc + longint'(s[i]);
                    if (acc > amax) begin
                        acc = amax; ovf = 1'b1;
                    end else if (acc < amin) begin
                        acc = amin; ovf = 1'b1;
                    end
                end
            endcase
        end
        if (s.size() == 0) acc = 64'sd0;
        av    = acc;
        e.o0  = av[31:0];
        e.o1  = av[63:32];
        e.st  = ovf ? 32'h6 : 32'h2;
        e.cnt = 32'(s.size());
        res_q.push_back(e);
    endtask

    // File-port responder: acks pending requests after ack_delay cycles.
    initial begin
        file_active    = 1'b0;
        file_read_data = 32'd0;
        wait_cnt       = 0;
        forever begin
            @(negedge clk);
            file_active = 1'b0;
            if (resp_en && rst_n && (file_read || file_write)) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt    = 0;
                    file_active = 1'b1;
                    if (file_read) begin
                        check_value("rd_num", file_num, src_cur);
                        if (rd_q.size() > 0) file_read_data = rd_q.pop_front();
                        else file_read_data = 32'hDEAD_BEEF;
                    end else begin
                        check_value("wr_num", file_num, dst_cur);
                        if (wr_exp_q.size() > 0) check_value("wr_data", file_write_data, wr_exp_q.pop_front());
                        else check_value("wr_extra", 1'b1, 1'b0);
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Run one complete operation and compare against the scoreboard.
    task automatic go(input string tag, input logic [2:0] op, input logic [31:0] coef, input int s[$],
                      input logic irq_en, input int ack_d, output int cyc_o);
        int irqs;
        bit fin;
        exp_t e;
        ack_delay = ack_d;
        model_push(op, coef, s);
        src_cur = 8'h10 + {5'd0, op};
        dst_cur = 8'h20 + {5'd0, op};
        in1 = {16'd0, dst_cur, src_cur};
        in2 = 32'(s.size());
        in3 = coef;
        in0 = {26'd0, 1'b0, irq_en, op, 1'b1};
        @(negedge clk);
        check_value({tag, "_start"}, start, 1'b1);
        check_value({tag, "_errclr"}, error, 1'b0);
        in0[0] = 1'b0;
        irqs  = int'(interrupt);
        cyc_o = 0;
        fin   = out2[1] | out2[3];
        while (!fin && cyc_o < 2000) begin
            @(negedge clk);
            cyc_o++;
            irqs += int'(interrupt);
            fin = out2[1] | out2[3];
        end
        if (!fin) check_value({tag, "_finish"}, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            irqs += int'(interrupt);
        end
        e = res_q.pop_front();
        check_value({tag, "_out0"}, out0, e.o0);
        check_value({tag, "_out1"}, out1, e.o1);
        check_value({tag, "_status"}, out2, e.st);
        check_value({tag, "_count"}, out3, e.cnt);
        check_value({tag, "_irqs"}, 64'(irqs), {63'd0, irq_en});
        check_value({tag, "_startlow"}, start, 1'b0);
        check_value({tag, "_rdleft"}, 64'(rd_q.size()), 64'd0);
        check_value({tag, "_wrleft"}, 64'(wr_exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int cyc, hi, irqs;
        rst_n = 1'b0;
        in0 = 32'd0; in1 = 32'd0; in2 = 32'd0; in3 = 32'd0;
        resp_en = 1'b1; ack_delay = 0; src_cur = 8'd0; dst_cur = 8'd0;
        repeat (3) @(negedge clk);
        check_value("rst_out0", out0, 32'd0);
        check_value("rst_out1", out1, 32'd0);
        check_value("rst_status", out2, 32'd0);
        check_value("rst_count", out3, 32'd0);
        check_value("rst_ctl", {start, interrupt, error, file_read, file_write}, 5'd0);
        check_value("rst_fnum", file_num, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        q = '{1, 2, 3, -10};
        go("sum", 3'd0, 32'd0, q, 1'b1, 0, cyc);
        q = '{-5, 7, 2};
        go("max", 3'd2, 32'd0, q, 1'b1, 2, cyc);
        go("min", 3'd1, 32'd0, q, 1'b0, 0, cyc);
        q.delete();
        go("min0", 3'd1, 32'd0, q, 1'b1, 0, cyc);
        check_value("min0_latency", 64'(cyc), 64'd0);
        q = '{3, 32'h7FFFFFFF};
        go("scale", 3'd3, 32'h0002_0000, q, 1'b1, 1, cyc);
        q = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        go("sat", 3'd0, 32'd0, q, 1'b0, 0, cyc);

        // Timeout: no acknowledge for a read request.
        resp_en = 1'b0;
        in1 = {16'd0, 8'h31, 8'h30}; in2 = 32'd2;
        in0 = {26'd0, 1'b0, 1'b1, 3'd0, 1'b1};
        @(negedge clk);
        check_value("tmo_start", start, 1'b1);
        in0[0] = 1'b0;
        hi = 0; irqs = 0;
        while (file_read && hi < TMO + 50) begin
            hi++;
            irqs += int'(interrupt);
            @(negedge clk);
        end
        check_value("tmo_req_len", 64'(hi), 64'(TMO));
        check_value("tmo_irq_early", 64'(irqs), 64'd0);
        check_value("tmo_irq", interrupt, 1'b1);
        check_value("tmo_error", error, 1'b1);
        check_value("tmo_status", out2, 32'h8);
        @(negedge clk);
        resp_en = 1'b1;
        q = '{5};
        go("rec", 3'd0, 32'd0, q, 1'b1, 0, cyc);

        // Abort while a SCALE write is pending.
        rd_q.push_back(4); rd_q.push_back(9);
        ack_delay = 5; src_cur = 8'h40; dst_cur = 8'h41;
        in1 = {16'd0, 8'h41, 8'h40}; in2 = 32'd2; in3 = 32'h0001_0000;
        in0 = {26'd0, 1'b0, 1'b1, 3'd3, 1'b1};
        @(negedge clk);
        in0[0] = 1'b0;
        cyc = 0;
        while (!file_write && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_value("abt_wr_seen", file_write, 1'b1);
        check_value("abt_wr_data", file_write_data, 32'd4);
        in0[5] = 1'b1;
        @(negedge clk);
        check_value("abt_wr_drop", file_write, 1'b0);
        check_value("abt_status", out2, 32'h10);
        check_value("abt_out0_kept", out0, 32'd5);
        irqs = int'(interrupt);
        repeat (3) begin
            @(negedge clk);
            irqs += int'(interrupt);
        end
        check_value("abt_no_irq", 64'(irqs), 64'd0);
        in0 = 32'd0;
        rd_q.delete(); wr_exp_q.delete();

        // Asynchronous reset in the middle of a read request.
        rd_q.push_back(7);
        ack_delay = 8; src_cur = 8'h50;
        in1 = {16'd0, 8'h51, 8'h50}; in2 = 32'd1;
        in0 = {26'd0, 1'b0, 1'b1, 3'd0, 1'b1};
        @(negedge clk);
        in0[0] = 1'b0;
        check_value("rstrd_req", file_read, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("rstrd_drop", file_read, 1'b0);
        check_value("rstrd_status", out2, 32'd0);
        check_value("rstrd_out0", out0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_q.delete();
        @(negedge clk);
        q = '{100, -300};
        go("post", 3'd0, 32'd0, q, 1'b1, 0, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
